// File: rtl/path_mon_pkg.sv
// Shared types for the path delay monitor: FSM state encoding and sizing helper.
// PATH_MON_SAMPLE_LOG_EN (default undefined) adds the sampleLog output to path_delay_monitor.
package path_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pathmon_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pathmon_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/path_delay_monitor.sv
// Launch/capture controller around a delay chain: toggles the chain input, samples its output
// CAPTURE_CYCLES edges later and counts late arrivals. PATH_MON_SAMPLE_LOG_EN adds sampleLog.
module path_delay_monitor
  import path_mon_pkg::*;
#(
  parameter int CAPTURE_CYCLES = 1,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TRIALS         = 256,
  parameter int THRESH         = 8,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             pathLaunch,
  input  logic             pathCapture,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] errCount,
  output logic             alarm
`ifdef PATH_MON_SAMPLE_LOG_EN
  ,
  output logic [7:0]       sampleLog
`endif
);

  localparam int TRIAL_W = $clog2(TRIALS + 1);
  localparam int WAIT_W  = $clog2(max2(CAPTURE_CYCLES, SETTLE_CYCLES) + 1);

  state_t             state;
  logic [TRIAL_W-1:0] trial_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               expected;
  logic               cap_reg;
  logic               accept;
  logic               mismatch;

  assign accept   = (state == ST_IDLE) && start;
  assign mismatch = cap_reg ^ expected;

  pathmon_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   ((state == ST_CHECK) && mismatch),
    .count (errCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pathLaunch <= 1'b0;
      expected   <= 1'b0;
      cap_reg    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      alarm      <= 1'b0;
      trial_cnt  <= '0;
      wait_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            alarm     <= 1'b0;
            trial_cnt <= '0;
            busy      <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          pathLaunch <= ~pathLaunch;
          expected   <= ~pathLaunch;
          wait_cnt   <= WAIT_W'(CAPTURE_CYCLES - 1);
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // the chain output is taken raw: the sampling edge itself is what is being measured
          if (wait_cnt == '0) begin
            cap_reg <= pathCapture;
            state   <= ST_CHECK;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        ST_CHECK: begin
          trial_cnt <= trial_cnt + TRIAL_W'(1);
          if (trial_cnt == TRIAL_W'(TRIALS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (SETTLE_CYCLES == 0) begin
            state <= ST_LAUNCH;
          end else begin
            wait_cnt <= WAIT_W'(SETTLE_CYCLES - 1);
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (wait_cnt == '0) begin
            state <= ST_LAUNCH;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        ST_DONE: begin
          alarm <= (32'(errCount) >= 32'(THRESH));
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PATH_MON_SAMPLE_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      sampleLog <= 8'd0;
    end else if (state == ST_CHECK) begin
      sampleLog <= {sampleLog[6:0], mismatch};
    end
  end
`endif

endmodule

// File: tb/tb_path_delay_monitor.sv
// Scoreboard bench for path_delay_monitor: run expectations are queued at start and checked at done.
module tb_path_delay_monitor;

  localparam int CAP    = 1;
  localparam int SET    = 4;
  localparam int TR     = 16;
  localparam int TH     = 4;
  localparam int PERIOD = CAP + SET + 2;
  // Negedges from start assertion to the DONE cycle; the final trial goes CHECK->DONE without settling.
  localparam int RUN_LAT = (TR - 1) * PERIOD + CAP + 3;

  typedef struct {
    int         lat;
    int         busy_n;
    int         errs;
    logic       alarm;
    logic [7:0] log;
  } exp_t;

  exp_t sb[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        launch, capture, busy, done, alarm;
  logic [15:0] err;
  logic        launch_s, capture_s, busy_s, done_s, alarm_s;
  logic [2:0]  err_s;
`ifdef PATH_MON_SAMPLE_LOG_EN
  logic [7:0]  log_m, log_s;
`endif

  int         mode = 0;    // 0 zero delay, 1 two-cycle delay, 2 stuck-at-0
  int         mode_s = 1;
  logic [1:0] dly = 2'b00;
  logic [1:0] dly_s = 2'b00;
  logic       pol = 1'b0;  // bench-tracked polarity of the chain input
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dly   <= {dly[0], launch};
    dly_s <= {dly_s[0], launch_s};
  end

  assign capture   = (mode == 0) ? launch : (mode == 1) ? dly[1] : 1'b0;
  assign capture_s = (mode_s == 0) ? launch_s : (mode_s == 1) ? dly_s[1] : 1'b0;

  path_delay_monitor #(
    .CAPTURE_CYCLES(CAP), .SETTLE_CYCLES(SET), .TRIALS(TR), .THRESH(TH), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .pathLaunch(launch), .pathCapture(capture),
    .busy(busy), .done(done), .errCount(err), .alarm(alarm)
`ifdef PATH_MON_SAMPLE_LOG_EN
    , .sampleLog(log_m)
`endif
  );

  path_delay_monitor #(
    .CAPTURE_CYCLES(CAP), .SETTLE_CYCLES(SET), .TRIALS(TR), .THRESH(TH), .CNT_W(3)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .pathLaunch(launch_s), .pathCapture(capture_s),
    .busy(busy_s), .done(done_s), .errCount(err_s), .alarm(alarm_s)
`ifdef PATH_MON_SAMPLE_LOG_EN
    , .sampleLog(log_s)
`endif
  );

  // Reference model of one run for a given path behaviour and starting polarity.
  task automatic push_expect(input int m, input logic pol0, input int max_cnt);
    exp_t e;
    logic p;
    logic fail;
    int errs;
    logic [7:0] lg;
    p = pol0;
    errs = 0;
    lg = 8'd0;
    for (int i = 0; i < TR; i++) begin
      p = ~p;
      fail = (m == 1) ? 1'b1 : (m == 2) ? p : 1'b0;
      if (fail && errs < max_cnt) errs++;
      lg = {lg[6:0], fail};
    end
    e.lat    = RUN_LAT;
    e.busy_n = RUN_LAT - 1;
    e.errs   = errs;
    e.alarm  = (errs >= TH);
    e.log    = lg;
    sb.push_back(e);
  endtask

  task automatic run_main(input string name, input int m, input int extra_start_at,
                          input bit start_in_done);
    exp_t e;
    int n;
    int busy_n;
    bit seen;
    mode = m;
    n = 0;
    busy_n = 0;
    seen = 1'b0;
    push_expect(m, pol, 65535);
    @(negedge clk);
    start = 1'b1;
    while (n < RUN_LAT + 50 && !seen) begin
      @(negedge clk);
      n++;
      start = (n == extra_start_at);
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL %s done timeout after %0d cycles", name, n); end
      n_checks++;
      if (n !== e.lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, n, e.lat); end
      n_checks++;
      if (busy_n !== e.busy_n) begin n_fail++; $display("FAIL %s busy cycles got %0d want %0d", name, busy_n, e.busy_n); end
      start = start_in_done;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL %s done width got done=%b want 0", name, done); end
      n_checks++;
      if (err !== 16'(e.errs)) begin n_fail++; $display("FAIL %s errCount got %0d want %0d", name, err, e.errs); end
      n_checks++;
      if (alarm !== e.alarm) begin n_fail++; $display("FAIL %s alarm got %b want %b", name, alarm, e.alarm); end
`ifdef PATH_MON_SAMPLE_LOG_EN
      n_checks++;
      if (log_m !== e.log) begin n_fail++; $display("FAIL %s sampleLog got %b want %b", name, log_m, e.log); end
`endif
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || err !== 16'(e.errs)) begin
        n_fail++;
        $display("FAIL %s idle hold busy=%b errCount=%0d want busy=0 errCount=%0d", name, busy, err, e.errs);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    start_s = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    start_s = 1'b0;
    @(negedge clk);
    n_checks++;
    if (launch !== 1'b0) begin n_fail++; $display("FAIL reset pathLaunch got %b want 0", launch); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b want 0", done); end
    n_checks++;
    if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset alarm got %b want 0", alarm); end
    n_checks++;
    if (err !== 16'd0) begin n_fail++; $display("FAIL reset errCount got %0d want 0", err); end
    n_checks++;
    if (busy_s !== 1'b0 || err_s !== 3'd0) begin
      n_fail++;
      $display("FAIL reset sat busy=%b errCount=%0d want 0/0", busy_s, err_s);
    end
  endtask

  task automatic test_fast();
    run_main("fast", 0, 0, 1'b0);
  endtask

  task automatic test_slow();
    run_main("slow", 1, 0, 1'b0);
  endtask

  task automatic test_stuck();
    run_main("stuck0", 2, 0, 1'b0);
  endtask

  task automatic test_ignore_start();
    run_main("ignore_start", 0, 30, 1'b1);
  endtask

  task automatic test_rst_midrun();
    bit saw_done;
    saw_done = 1'b0;
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 49; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pol = 1'b0;
    n_checks++;
    if (launch !== 1'b0 || err !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_midrun launch=%b errCount=%0d busy=%b want 0/0/0", launch, err, busy);
    end
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_midrun done pulse got %b want 0", saw_done); end
  endtask

  task automatic test_saturation();
    exp_t e;
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    mode_s = 1;
    push_expect(1, 1'b0, 7);
    @(negedge clk);
    start_s = 1'b1;
    while (n < RUN_LAT + 50 && !seen) begin
      @(negedge clk);
      n++;
      start_s = 1'b0;
      if (done_s) seen = 1'b1;
    end
    e = sb.pop_front();
    n_checks++;
    if (!seen || n !== e.lat) begin n_fail++; $display("FAIL sat latency got %0d want %0d", n, e.lat); end
    @(negedge clk);
    n_checks++;
    if (err_s !== 3'(e.errs)) begin n_fail++; $display("FAIL sat errCount got %0d want %0d", err_s, e.errs); end
    n_checks++;
    if (alarm_s !== e.alarm) begin n_fail++; $display("FAIL sat alarm got %b want %b", alarm_s, e.alarm); end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_slow();
    test_stuck();
    test_ignore_start();
    test_rst_midrun();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
